// File: rtl/tia_biphase_dl_if.sv
// Signal bundle for the TIA biphase generator and delay latch.
// The slave side is the generator; the master side drives the DL inputs and observes the phases.
interface tia_biphase_dl_if;
  logic phi1;
  logic phi2;
  logic rl;
  logic dl_in;
  logic dl_r;
  logic dl_out;

  modport slave (
    output phi1,
    output phi2,
    output rl,
    input  dl_in,
    input  dl_r,
    output dl_out
  );

  modport master (
    input  phi1,
    input  phi2,
    input  rl,
    output dl_in,
    output dl_r,
    input  dl_out
  );
endinterface

// File: rtl/tia_biphase_dl.sv
// TIA two-phase clock generator (phi1, gap, phi2, gap) with a sticky set/clear delay latch.
// The latch samples during phi1 and updates its output on the edge raising phi2.
module tia_biphase_dl (
  input  logic              clk,
  input  logic              r,
  tia_biphase_dl_if.slave   bus
);

  logic [1:0] state_q, state_d;
  logic       phi1_q, phi1_d;
  logic       phi2_q, phi2_d;
  logic       rl_q, rl_d;
  logic       in_s_q, in_s_d;
  logic       r_s_q, r_s_d;
  logic       dl_out_q, dl_out_d;

  always_comb begin
    state_d  = state_q + 2'd1;
    // Phases are registered from the state being entered so they align with it.
    phi1_d   = (state_d == 2'd0);
    phi2_d   = (state_d == 2'd2);
    rl_d     = 1'b0;
    in_s_d   = in_s_q;
    r_s_d    = r_s_q;
    dl_out_d = dl_out_q;

    if (state_q == 2'd0) begin
      in_s_d = bus.dl_in;
      r_s_d  = bus.dl_r;
    end

    // Clear dominates set; the output otherwise only accumulates ones.
    if (state_q == 2'd1) begin
      dl_out_d = r_s_q ? 1'b0 : (dl_out_q | in_s_q);
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q  <= 2'd3;
      phi1_q   <= 1'b0;
      phi2_q   <= 1'b0;
      rl_q     <= 1'b1;
      in_s_q   <= 1'b0;
      r_s_q    <= 1'b0;
      dl_out_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      phi1_q   <= phi1_d;
      phi2_q   <= phi2_d;
      rl_q     <= rl_d;
      in_s_q   <= in_s_d;
      r_s_q    <= r_s_d;
      dl_out_q <= dl_out_d;
    end
  end

  assign bus.phi1   = phi1_q;
  assign bus.phi2   = phi2_q;
  assign bus.rl     = rl_q;
  assign bus.dl_out = dl_out_q;

endmodule

// File: tb/tb_tia_biphase_dl.sv
// Self-checking bench for tia_biphase_dl: directed period sequence, then randomized
// inputs with occasional mid-period resets, compared against a period-level model.
module tb_tia_biphase_dl;

  logic clk;
  logic r;
  tia_biphase_dl_if bus ();

  tia_biphase_dl dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert;
  int n_fail;

  // Model: edges since reset release, the period's captured inputs, and the latch value.
  int   k;
  int   pos;
  logic s_in;
  logic s_r;
  logic dl_m;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: update the model for the edge just taken, drive new inputs, check at negedge.
  task automatic cycle(input logic din, input logic dr);
    @(posedge clk);
    #1;
    k++;
    pos = (k - 1) % 4;
    if (pos == 2) dl_m = s_r ? 1'b0 : (dl_m | s_in);
    bus.dl_in = din;
    bus.dl_r  = dr;
    if (pos == 0) begin
      s_in = din;
      s_r  = dr;
    end
    @(negedge clk);
    check("phi1", bus.phi1, (pos == 0));
    check("phi2", bus.phi2, (pos == 2));
    check("no_overlap", bus.phi1 & bus.phi2, 1'b0);
    check("rl", bus.rl, 1'b0);
    check("dl_out", bus.dl_out, dl_m);
  endtask

  // Assert reset mid-cycle, verify immediate effect, hold across an edge, release at negedge.
  task automatic do_reset();
    #1;
    r = 1'b1;
    #1;
    check("rst_phi1", bus.phi1, 1'b0);
    check("rst_phi2", bus.phi2, 1'b0);
    check("rst_rl", bus.rl, 1'b1);
    check("rst_dl_out", bus.dl_out, 1'b0);
    @(posedge clk);
    #1;
    check("rst_hold_phi1", bus.phi1, 1'b0);
    check("rst_hold_rl", bus.rl, 1'b1);
    @(negedge clk);
    r    = 1'b0;
    k    = 0;
    s_in = 1'b0;
    s_r  = 1'b0;
    dl_m = 1'b0;
  endtask

  // Directed periods: inputs held for the whole period, expected dl_out at phi2.
  logic dir_in  [12] = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0};
  logic dir_r   [12] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0};
  logic dir_exp [12] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    k         = 0;
    pos       = 0;
    s_in      = 1'b0;
    s_r       = 1'b0;
    dl_m      = 1'b0;
    r         = 1'b1;
    bus.dl_in = 1'b0;
    bus.dl_r  = 1'b0;

    repeat (2) @(negedge clk);
    check("init_rl", bus.rl, 1'b1);
    check("init_phi1", bus.phi1, 1'b0);
    check("init_phi2", bus.phi2, 1'b0);
    check("init_dl_out", bus.dl_out, 1'b0);
    r = 1'b0;

    for (int p = 0; p < 12; p++) begin
      for (int c = 0; c < 4; c++) begin
        cycle(dir_in[p], dir_r[p]);
        if (c == 2) check($sformatf("dir_p%0d_phi2_dl", p), bus.dl_out, dir_exp[p]);
      end
      $display("period %0d dl_in=%0b dl_r=%0b dl_out=%0b", p, dir_in[p], dir_r[p], bus.dl_out);
    end

    // Mid-period reset with the latch set.
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    check("pre_reset_dl_set", bus.dl_out, 1'b1);
    do_reset();
    cycle(1'b0, 1'b0);
    check("restart_phi1", bus.phi1, 1'b1);
    $display("mid-period reset done, phi1=%0b rl=%0b", bus.phi1, bus.rl);

    // Randomized inputs every cycle, biased toward set, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic din, dr;
      din = ($urandom_range(0, 2) != 0);
      dr  = ($urandom_range(0, 4) == 0);
      cycle(din, dr);
      if ($urandom_range(0, 79) == 0) begin
        do_reset();
        $display("random reset at cycle %0d", i);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
